// File: rtl/frame_serializer_pkg.sv
// +-----------------------------------------------------------------------------+
// | frame_serializer_pkg : state encoding and default frame width               |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

package frame_serializer_pkg;

    localparam int c_FRAME_W_DEF = 11;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_SEND = 2'd1;
    localparam logic [1:0] c_ST_GAP  = 2'd2;
    localparam logic [1:0] c_ST_FIN  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = c_ST_IDLE,
        ST_SEND = c_ST_SEND,
        ST_GAP  = c_ST_GAP,
        ST_FIN  = c_ST_FIN
    } state_e;

endpackage

`default_nettype wire

// File: rtl/frame_serializer_if.sv
// +-----------------------------------------------------------------------------+
// | frame_serializer_if : parallel frame in, serial line and status out         |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

interface frame_serializer_if #(
    parameter int FRAME_W = frame_serializer_pkg::c_FRAME_W_DEF
) ();
    logic [FRAME_W-1:0] frame;
    logic               start;
    logic               txd;
    logic               busy;
    logic               done;

    modport master (output frame, output start, input txd, input busy, input done);
    modport slave  (input frame, input start, output txd, output busy, output done);
endinterface

`default_nettype wire

// File: rtl/frame_serializer_bit_timer.sv
// +-----------------------------------------------------------------------------+
// | frame_serializer_bit_timer : divides clk into bit times, tick on last clock |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

module frame_serializer_bit_timer #(
    parameter int DIV = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o
);
    localparam int              c_CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(DIV - 1);

    logic [c_CNT_W-1:0] div_cnt_q;
    logic [c_CNT_W-1:0] div_cnt_d;

    always_comb begin
        div_cnt_d = div_cnt_q;
        if (clr_i) begin
            div_cnt_d = '0;
        end else if (en_i) begin
            div_cnt_d = (div_cnt_q == c_LAST) ? '0 : div_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

    assign tick_o = en_i && !clr_i && (div_cnt_q == c_LAST);

endmodule

`default_nettype wire

// File: rtl/frame_serializer.sv
// +-----------------------------------------------------------------------------+
// | frame_serializer : LSB-first serializer with idle-high gap and done pulse   |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

module frame_serializer
    import frame_serializer_pkg::*;
#(
    parameter int FRAME_W  = c_FRAME_W_DEF,
    parameter int DIV      = 16,
    parameter int GAP_BITS = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    frame_serializer_if.slave  bus
);
    localparam int                 c_BIT_W    = $clog2(FRAME_W + 1);
    localparam logic [c_BIT_W-1:0] c_LAST_BIT = c_BIT_W'(FRAME_W - 1);
    localparam int                 c_GAP_W    = (GAP_BITS > 0) ? $clog2(GAP_BITS + 1) : 1;
    localparam logic [c_GAP_W-1:0] c_LAST_GAP = c_GAP_W'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

    state_e               state_q;
    logic [FRAME_W-1:0]   shreg_q;
    logic [FRAME_W-1:0]   shreg_d;
    logic [c_BIT_W-1:0]   bit_cnt_q;
    logic [c_GAP_W-1:0]   gap_cnt_q;
    logic                 txd_q;
    logic                 busy_q;
    logic                 done_q;

    logic                 timer_en;
    logic                 timer_clr;
    logic                 bit_tick;

    assign timer_en  = (state_q == ST_SEND) || (state_q == ST_GAP);
    assign timer_clr = !timer_en;
    assign shreg_d   = {1'b1, shreg_q[FRAME_W-1:1]};

    // The gap reuses the bit timer, so gap_cnt counts whole bit times.
    frame_serializer_bit_timer #(
        .DIV (DIV)
    ) u_bit_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (timer_clr),
        .en_i   (timer_en),
        .tick_o (bit_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '1;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            txd_q     <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    txd_q     <= 1'b1;
                    busy_q    <= 1'b0;
                    bit_cnt_q <= '0;
                    gap_cnt_q <= '0;
                    if (bus.start) begin
                        shreg_q <= bus.frame;
                        txd_q   <= bus.frame[0];
                        busy_q  <= 1'b1;
                        state_q <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (bit_tick) begin
                        shreg_q   <= shreg_d;
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        txd_q     <= shreg_d[0];
                        if (bit_cnt_q == c_LAST_BIT) begin
                            bit_cnt_q <= '0;
                            txd_q     <= 1'b1;
                            if (GAP_BITS > 0) begin
                                state_q <= ST_GAP;
                            end else begin
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= ST_FIN;
                            end
                        end
                    end
                end
                ST_GAP: begin
                    txd_q <= 1'b1;
                    if (bit_tick) begin
                        if (gap_cnt_q == c_LAST_GAP) begin
                            gap_cnt_q <= '0;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                            state_q   <= ST_FIN;
                        end else begin
                            gap_cnt_q <= gap_cnt_q + 1'b1;
                        end
                    end
                end
                ST_FIN: begin
                    txd_q   <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    txd_q   <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.txd  = txd_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

`default_nettype wire
